// File: rtl/sample_bus_arbiter.sv
// Shared sample-bus arbiter: fixed top priority for the DMA port (index 0), round-robin
// among the other masters, a one-cycle turnaround between owners and a hold-time watchdog.
module sample_bus_arbiter #(
    parameter int NREQ     = 3,
    parameter int MAX_HOLD = 16
) (
    input  logic            clk,
    input  logic            reset,
    input  logic [NREQ-1:0] breq,
    output logic [NREQ-1:0] bgrant,
    output logic [2:0]      owner,
    output logic            owner_valid,
    output logic            timeout,
    output logic [2:0]      timeout_id,
    output logic [NREQ-1:0] mask
);

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        GRANT = 2'd1,
        TURN  = 2'd2
    } state_t;

    state_t          state_r;
    logic [2:0]      rr_ptr_r;
    logic [7:0]      hold_cnt_r;
    logic [NREQ-1:0] elig_s;
    logic            any_elig_s;
    logic [2:0]      sel_s;
    logic            owner_req_s;
    logic            expire_s;

    // Winner selection: index 0 first, otherwise the nearest eligible index after rr_ptr in 1..NREQ-1
    always_comb begin
        int best_d;
        int d;
        elig_s     = breq & ~mask;
        any_elig_s = |elig_s;
        sel_s      = 3'd0;
        best_d     = NREQ;
        d          = 0;
        if (elig_s[0]) begin
            sel_s = 3'd0;
        end else begin
            for (int i = 1; i < NREQ; i++) begin
                d      = (i - int'(rr_ptr_r) - 1 + 2 * (NREQ - 1)) % (NREQ - 1);
                sel_s  = (elig_s[i] && (d < best_d)) ? 3'(i) : sel_s;
                best_d = (elig_s[i] && (d < best_d)) ? d : best_d;
            end
        end
    end

    // The current owner is still requesting; expiry only counts while it still wants the bus
    always_comb begin
        owner_req_s = |(breq & bgrant);
        expire_s    = (MAX_HOLD != 0) && (hold_cnt_r == 8'(MAX_HOLD)) && owner_req_s;
    end

    // Arbitration FSM with registered grant, owner, watchdog and mask outputs
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_r     <= IDLE;
            bgrant      <= '0;
            owner       <= 3'd0;
            owner_valid <= 1'b0;
            timeout     <= 1'b0;
            timeout_id  <= 3'd0;
            mask        <= '0;
            rr_ptr_r    <= 3'(NREQ - 1);
            hold_cnt_r  <= 8'd0;
        end else begin
            timeout <= 1'b0;
            mask    <= mask & breq;
            case (state_r)
                IDLE, TURN: begin
                    if (any_elig_s) begin
                        state_r     <= GRANT;
                        bgrant      <= NREQ'(1'b1) << sel_s;
                        owner       <= sel_s;
                        owner_valid <= 1'b1;
                        hold_cnt_r  <= 8'd1;
                        if (sel_s != 3'd0) begin
                            rr_ptr_r <= sel_s;
                        end else begin
                            rr_ptr_r <= rr_ptr_r;
                        end
                    end else begin
                        state_r <= IDLE;
                    end
                end
                GRANT: begin
                    if (!owner_req_s) begin
                        state_r     <= TURN;
                        bgrant      <= '0;
                        owner_valid <= 1'b0;
                    end else if (expire_s) begin
                        // Revoked master stays masked until it drops breq
                        state_r     <= TURN;
                        bgrant      <= '0;
                        owner_valid <= 1'b0;
                        timeout     <= 1'b1;
                        timeout_id  <= owner;
                        mask        <= (mask & breq) | bgrant;
                    end else if (hold_cnt_r != 8'hFF) begin
                        hold_cnt_r <= hold_cnt_r + 8'd1;
                    end else begin
                        hold_cnt_r <= hold_cnt_r;
                    end
                end
                default: begin
                    state_r     <= IDLE;
                    bgrant      <= '0;
                    owner_valid <= 1'b0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_sample_bus_arbiter.sv
// Self-checking bench for sample_bus_arbiter: directed scenarios plus random requests
// compared cycle by cycle against a behavioural bus-ownership model.
module tb_sample_bus_arbiter;

    localparam int NREQ     = 3;
    localparam int MAX_HOLD = 16;

    logic            clk = 1'b0;
    logic            reset;
    logic [NREQ-1:0] breq;
    logic [NREQ-1:0] bgrant;
    logic [2:0]      owner;
    logic            owner_valid;
    logic            timeout;
    logic [2:0]      timeout_id;
    logic [NREQ-1:0] mask;

    sample_bus_arbiter #(.NREQ(NREQ), .MAX_HOLD(MAX_HOLD)) dut (
        .clk        (clk),
        .reset      (reset),
        .breq       (breq),
        .bgrant     (bgrant),
        .owner      (owner),
        .owner_valid(owner_valid),
        .timeout    (timeout),
        .timeout_id (timeout_id),
        .mask       (mask)
    );

    always #5 clk = ~clk;

    int n_checks = 0;
    int n_errors = 0;

    // Reference model: who holds the bus, for how long, who was last served round-robin
    int              m_owner;
    int              m_hold;
    int              m_rr;
    int              m_toid;
    bit              m_to;
    logic [NREQ-1:0] m_mask;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        if (obs !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h at %0t", tag, obs, exp, $time);
        end
    endtask

    function automatic bit bit_at(input logic [NREQ-1:0] v, input int i);
        logic [NREQ-1:0] t;
        t = v >> i;
        return t[0];
    endfunction

    function automatic int pick(input logic [NREQ-1:0] b);
        logic [NREQ-1:0] e;
        int idx;
        e = b & ~m_mask;
        if (bit_at(e, 0)) return 0;
        for (int k = 1; k < NREQ; k++) begin
            idx = ((m_rr - 1 + k) % (NREQ - 1)) + 1;
            if (bit_at(e, idx)) return idx;
        end
        return -1;
    endfunction

    task automatic model_reset();
        m_owner = -1;
        m_hold  = 0;
        m_rr    = NREQ - 1;
        m_toid  = 0;
        m_to    = 1'b0;
        m_mask  = '0;
    endtask

    // One clock edge of the model, using the request vector sampled at that edge
    task automatic model_step(input logic [NREQ-1:0] b);
        logic [NREQ-1:0] nm;
        int p;
        nm   = m_mask & b;
        m_to = 1'b0;
        if (m_owner >= 0) begin
            if (!bit_at(b, m_owner)) begin
                m_owner = -1;
            end else if (MAX_HOLD > 0 && m_hold == MAX_HOLD) begin
                nm      = nm | (NREQ'(1) << m_owner);
                m_to    = 1'b1;
                m_toid  = m_owner;
                m_owner = -1;
            end else if (m_hold < 255) begin
                m_hold++;
            end
        end else begin
            p = pick(b);
            if (p >= 0) begin
                m_owner = p;
                m_hold  = 1;
                if (p > 0) m_rr = p;
            end
        end
        m_mask = nm;
    endtask

    task automatic compare_all();
        chk("bgrant", 32'(bgrant), (m_owner >= 0) ? (32'd1 << m_owner) : 32'd0);
        chk("owner_valid", 32'(owner_valid), (m_owner >= 0) ? 32'd1 : 32'd0);
        if (m_owner >= 0) chk("owner", 32'(owner), 32'(m_owner));
        chk("timeout", 32'(timeout), 32'(m_to));
        chk("timeout_id", 32'(timeout_id), 32'(m_toid));
        chk("mask", 32'(mask), 32'(m_mask));
    endtask

    task automatic cycle(input logic [NREQ-1:0] b);
        breq = b;
        @(posedge clk);
        model_step(b);
        #1;
        compare_all();
    endtask

    initial begin
        int held;
        int cnt;
        int to_cnt;
        int to_id;
        int seq[$];
        bit prev_valid;
        logic [NREQ-1:0] b;

        reset = 1'b1;
        breq  = '0;
        model_reset();
        #12;
        compare_all();
        reset = 1'b0;

        // Single request from the DMA port
        cycle(3'b001);
        chk("single_grant", 32'(bgrant), 32'b001);
        repeat (4) cycle(3'b001);
        cycle(3'b000);
        chk("single_release", 32'(bgrant), 32'b000);
        repeat (2) cycle(3'b000);

        // Priority and no preemption
        cycle(3'b110);
        chk("prio_first", 32'(bgrant), 32'b010);
        repeat (2) cycle(3'b111);
        chk("no_preempt", 32'(bgrant), 32'b010);
        cycle(3'b101);
        chk("prio_gap", 32'(bgrant), 32'b000);
        cycle(3'b101);
        chk("prio_dma_next", 32'(bgrant), 32'b001);
        repeat (2) cycle(3'b000);

        // Round-robin between masters 1 and 2 with two-cycle tenures
        held = 0;
        prev_valid = 1'b0;
        for (int c = 0; c < 24; c++) begin
            b = 3'b110;
            if (owner_valid && held >= 2) b = b & ~bgrant;
            cycle(b);
            if (owner_valid && !prev_valid) seq.push_back(int'(owner));
            held = owner_valid ? held + 1 : 0;
            prev_valid = owner_valid;
        end
        chk("rr_count", 32'(seq.size() >= 4), 32'd1);
        if (seq.size() >= 4) begin
            chk("rr_seq0", 32'(seq[0]), 32'd2);
            chk("rr_seq1", 32'(seq[1]), 32'd1);
            chk("rr_seq2", 32'(seq[2]), 32'd2);
            chk("rr_seq3", 32'(seq[3]), 32'd1);
        end
        repeat (2) cycle(3'b000);

        // Watchdog on master 2
        cnt = 0;
        to_cnt = 0;
        to_id = 0;
        for (int c = 0; c < 25; c++) begin
            cycle(3'b100);
            if (bgrant == 3'b100) cnt++;
            if (timeout) begin
                to_cnt++;
                to_id = int'(timeout_id);
            end
        end
        chk("wd_tenure", 32'(cnt), 32'(MAX_HOLD));
        chk("wd_pulses", 32'(to_cnt), 32'd1);
        chk("wd_id", 32'(to_id), 32'd2);
        chk("wd_mask", 32'(mask), 32'b100);
        cycle(3'b000);
        chk("wd_unmask", 32'(mask), 32'b000);
        cycle(3'b100);
        chk("wd_regrant", 32'(bgrant), 32'b100);
        repeat (2) cycle(3'b000);

        // Release exactly at expiry is a normal release
        repeat (MAX_HOLD) cycle(3'b010);
        cycle(3'b000);
        chk("exp_rel_timeout", 32'(timeout), 32'd0);
        chk("exp_rel_mask", 32'(mask), 32'b000);
        cycle(3'b000);

        // Asynchronous reset mid-tenure
        repeat (2) cycle(3'b010);
        chk("mid_grant", 32'(bgrant), 32'b010);
        #2;
        reset = 1'b1;
        #1;
        model_reset();
        chk("async_bgrant", 32'(bgrant), 32'b000);
        compare_all();
        breq = 3'b110;
        @(negedge clk);
        reset = 1'b0;
        cycle(3'b110);
        chk("post_reset_grant", 32'(bgrant), 32'b010);
        repeat (2) cycle(3'b000);

        // Random requests, mostly held with occasional toggles
        b = '0;
        for (int c = 0; c < 3000; c++) begin
            for (int i = 0; i < NREQ; i++) begin
                if ($urandom_range(0, 7) == 0) b[i] = ~b[i];
            end
            cycle(b);
        end

        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
